wb_select_stage: RTL and testbench
==================================

// Module: wb_select_stage
// PURPOSE
//  Parametrised writeback-select pipeline stage between DM and the register file.
//  Priority-selects one of NUM_SRC result lanes (DM, IM, PC/JAL, ext ALU, stack, ALU).
//  Registers the selected result with its destination address and write enable.
//  Adds a valid/ready handshake, flush, and a wait state for a multi-cycle external ALU
//  result, with a timeout. Exposes a forwarding tap to the hazard/bypass logic.
// PARAMETERS
//  WIDTH       32  data width of every lane and of the output
//  NUM_SRC     6   number of source lanes; lane 0 has the highest priority
//  ADDR_W      4   register-file address width
//  DEFAULT_IDX 5   lane used when no src_sel bit is set (ALU)
//  EXT_IDX     3   lane whose data comes from ext_data/ext_vld; src_data lane EXT_IDX is ignored
//  EXT_TIMEOUT 64  max cycles spent in WAIT_EXT before an error completion; must be >= 1
// PORTS
//  clk          in   1               clock, rising edge
//  rst_n        in   1               asynchronous active-low reset
//  in_vld       in   1               upstream result valid
//  in_rdy       out  1               stage can accept (combinational)
//  src_sel      in   NUM_SRC         source request bits; lowest set index wins
//  src_data     in   NUM_SRC*WIDTH   lane i = src_data[i*WIDTH +: WIDTH]
//  dst_addr     in   ADDR_W          destination register
//  we_in        in   1               RF write requested
//  ext_vld      in   1               external ALU result valid (level)
//  ext_data     in   WIDTH           external ALU result
//  flush        in   1               synchronous kill of all held/pending work
//  out_vld      out  1               rf_w_data/addr/we valid
//  out_rdy      in   1               RF consumes the entry on out_vld && out_rdy
//  rf_w_data    out  WIDTH           registered write data
//  rf_w_addr    out  ADDR_W          registered write address
//  rf_we        out  1               registered write enable (0 on error or we_in=0)
//  ext_err      out  1               registered; entry completed by ext timeout
//  fwd_vld      out  1               out_vld && rf_we, for bypass
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; out_vld, rf_we and ext_err = 0; rf_w_data = 0;
//    rf_w_addr = 0; timeout counter = 0; pending address/we = 0.
//  Output register is one entry. free = !out_vld || out_rdy.
//  in_rdy = (state==IDLE) && free && !flush.
//  Accept happens on in_vld && in_rdy. Lane sel = lowest set bit of src_sel, else DEFAULT_IDX.
//  Accept, sel != EXT_IDX: the next edge loads the output with lane data, dst_addr and we_in;
//    out_vld=1, ext_err=0. Latency is 1 cycle.
//  Accept, sel == EXT_IDX and ext_vld=1 in the same cycle: loads ext_data directly, 1 cycle.
//  Accept, sel == EXT_IDX and ext_vld=0: capture dst_addr/we_in into pending registers;
//    counter=0; go to WAIT_EXT; the output is not loaded.
//  WAIT_EXT, each cycle:
//    if ext_vld && free: load ext_data with the pending addr/we, ext_err=0, go IDLE.
//    else if counter == EXT_TIMEOUT-1 && free: load data=0, we=0, ext_err=1, go IDLE.
//    else: counter += 1, saturating at EXT_TIMEOUT-1. If ext_vld arrives while !free,
//      it is not latched; the ext unit holds ext_vld until it is consumed.
//  out_vld && out_rdy with no new load: out_vld <= 0 next edge; data, addr and we hold.
//  out_vld && !out_rdy: all outputs hold stable; in_rdy=0.
//  Simultaneous consume + load: back-to-back; out_vld stays 1 with the new entry.
//  flush=1 (priority over everything): next edge out_vld=0, rf_we=0, ext_err=0,
//    state=IDLE, counter=0. No accept occurs in a flush cycle.
//  Reset mid-WAIT_EXT: returns to IDLE and the pending work is dropped.
//  fwd_vld is combinational from the registers; it never depends on in_* ports.
//  Widths: no arithmetic on data; the counter is $clog2(EXT_TIMEOUT)+1 bits.
// TESTING
//  T1 priority: src_sel=6'b010100, lane2=32'hAAAA_0002, lane4=32'h4444_0004, dst=7,
//    we=1 -> next cycle out_vld=1, rf_w_data=AAAA_0002, rf_w_addr=7, rf_we=1.
//  T2 default + backpressure: src_sel=0, lane5=32'h1234, out_rdy=0 for 3 cycles ->
//    outputs stable, in_rdy=0; out_rdy=1 -> out_vld drops next cycle.
//  T3 ext wait: src_sel=6'b001000, ext_vld=0, ext_vld=1 with data DEAD_BEEF 5 cycles later
//    -> in_rdy=0 throughout; out_vld the cycle after ext_vld, rf_w_data=DEAD_BEEF.
//  T4 ext timeout: EXT_TIMEOUT=4, ext_vld never asserted -> after 4 cycles in WAIT_EXT:
//    out_vld=1, ext_err=1, rf_we=0, rf_w_data=0.
//  T5 streaming: 8 ALU results back to back with out_rdy=1 -> one out_vld per cycle,
//    in order, no bubbles, fwd_vld tracks rf_we.
//  T6 flush/reset: flush in WAIT_EXT, and rst_n low with out_vld=1 -> both reach IDLE
//    with out_vld=0; a late ext_vld produces no output.

Source files
------------

// File: rtl/wb_select_stage_if.sv
// Writeback-select stage bus: upstream result lanes, external ALU return, RF write port.
interface wb_select_stage_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_SRC = 6,
  parameter int unsigned ADDR_W  = 4
);
  logic                     in_vld;
  logic                     in_rdy;
  logic [NUM_SRC-1:0]       src_sel;
  logic [NUM_SRC*WIDTH-1:0] src_data;
  logic [ADDR_W-1:0]        dst_addr;
  logic                     we_in;
  logic                     ext_vld;
  logic [WIDTH-1:0]         ext_data;
  logic                     flush;
  logic                     out_vld;
  logic                     out_rdy;
  logic [WIDTH-1:0]         rf_w_data;
  logic [ADDR_W-1:0]        rf_w_addr;
  logic                     rf_we;
  logic                     ext_err;
  logic                     fwd_vld;

  modport master (
    output in_vld, src_sel, src_data, dst_addr, we_in, ext_vld, ext_data, flush, out_rdy,
    input  in_rdy, out_vld, rf_w_data, rf_w_addr, rf_we, ext_err, fwd_vld
  );

  modport slave (
    input  in_vld, src_sel, src_data, dst_addr, we_in, ext_vld, ext_data, flush, out_rdy,
    output in_rdy, out_vld, rf_w_data, rf_w_addr, rf_we, ext_err, fwd_vld
  );
endinterface

// File: rtl/wb_select_stage.sv
// Writeback-select stage: priority lane select into a one-entry RF write register,
// with a bounded wait for a multi-cycle external ALU result.
module wb_select_stage #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned NUM_SRC     = 6,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned DEFAULT_IDX = 5,
  parameter int unsigned EXT_IDX     = 3,
  parameter int unsigned EXT_TIMEOUT = 64
) (
  input logic               clk,
  input logic               rst_n,
  wb_select_stage_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(EXT_TIMEOUT) + 1;
  localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXT_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] SEL_EXT  = IDX_W'(EXT_IDX);

  typedef enum logic {ST_IDLE, ST_WAIT_EXT} state_e;

  state_e             state_q, state_d;
  logic               out_vld_q, out_vld_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               we_q, we_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  paddr_q, paddr_d;
  logic               pwe_q, pwe_d;

  logic               free;
  logic               in_rdy_c;
  logic               accept;
  logic [IDX_W-1:0]   sel;
  logic               sel_found;
  logic [WIDTH-1:0]   lane_data;

  assign free     = !out_vld_q || bus.out_rdy;
  assign in_rdy_c = (state_q == ST_IDLE) && free && !bus.flush;
  assign accept   = bus.in_vld && in_rdy_c;

  // Lowest set request bit wins; no request falls back to the default lane.
  always_comb begin
    sel       = IDX_W'(DEFAULT_IDX);
    sel_found = 1'b0;
    lane_data = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (!sel_found && bus.src_sel[i]) begin
        sel       = IDX_W'(i);
        sel_found = 1'b1;
      end
    end
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (sel == IDX_W'(i)) lane_data = bus.src_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d   = state_q;
    out_vld_d = out_vld_q;
    data_d    = data_q;
    addr_d    = addr_q;
    we_d      = we_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    paddr_d   = paddr_q;
    pwe_d     = pwe_q;

    if (out_vld_q && bus.out_rdy) out_vld_d = 1'b0;

    if (bus.flush) begin
      out_vld_d = 1'b0;
      we_d      = 1'b0;
      err_d     = 1'b0;
      cnt_d     = '0;
      state_d   = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (sel == SEL_EXT && !bus.ext_vld) begin
              paddr_d = bus.dst_addr;
              pwe_d   = bus.we_in;
              cnt_d   = '0;
              state_d = ST_WAIT_EXT;
            end else begin
              out_vld_d = 1'b1;
              data_d    = (sel == SEL_EXT) ? bus.ext_data : lane_data;
              addr_d    = bus.dst_addr;
              we_d      = bus.we_in;
              err_d     = 1'b0;
            end
          end
        end
        ST_WAIT_EXT: begin
          if (bus.ext_vld && free) begin
            out_vld_d = 1'b1;
            data_d    = bus.ext_data;
            addr_d    = paddr_q;
            we_d      = pwe_q;
            err_d     = 1'b0;
            state_d   = ST_IDLE;
          end else if (cnt_q == CNT_LAST && free) begin
            // Timed out: complete the entry without writing the register file.
            out_vld_d = 1'b1;
            data_d    = '0;
            addr_d    = paddr_q;
            we_d      = 1'b0;
            err_d     = 1'b1;
            state_d   = ST_IDLE;
          end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      out_vld_q <= 1'b0;
      data_q    <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      paddr_q   <= '0;
      pwe_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_vld_q <= out_vld_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      paddr_q   <= paddr_d;
      pwe_q     <= pwe_d;
    end
  end

  assign bus.in_rdy    = in_rdy_c;
  assign bus.out_vld   = out_vld_q;
  assign bus.rf_w_data = data_q;
  assign bus.rf_w_addr = addr_q;
  assign bus.rf_we     = we_q;
  assign bus.ext_err   = err_q;
  assign bus.fwd_vld   = out_vld_q && we_q;
endmodule

// File: tb/tb_wb_select_stage.sv
// Bench for wb_select_stage: directed scenarios plus random traffic on two instances
// (default and short ext timeout), checked against a transaction-level model.
`timescale 1ns/1ps
module tb_wb_select_stage;
  localparam int unsigned WIDTH   = 32;
  localparam int unsigned NUM_SRC = 6;
  localparam int unsigned ADDR_W  = 4;
  localparam int          DEF_IDX = 5;
  localparam int          EXT_IDX = 3;
  localparam int          TO_A    = 64;
  localparam int          TO_B    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit                        in_vld;
    logic [NUM_SRC-1:0]        sel;
    logic [NUM_SRC*WIDTH-1:0]  sdata;
    logic [ADDR_W-1:0]         dst;
    bit                        we;
    bit                        ext_vld;
    logic [WIDTH-1:0]          ext_data;
    bit                        flush;
    bit                        out_rdy;
  } stim_t;

  typedef struct {
    bit                vld;
    logic [WIDTH-1:0]  data;
    logic [ADDR_W-1:0] addr;
    bit                we;
    bit                err;
    bit                waiting;
    int                waited;
    logic [ADDR_W-1:0] paddr;
    bit                pwe;
  } mdl_t;

  stim_t sa, sb;
  mdl_t  ma, mb;
  int checks = 0;
  int errors = 0;

  wb_select_stage_if #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .ADDR_W(ADDR_W)) ba ();
  wb_select_stage_if #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .ADDR_W(ADDR_W)) bb ();

  assign ba.in_vld = sa.in_vld;  assign ba.src_sel = sa.sel;  assign ba.src_data = sa.sdata;
  assign ba.dst_addr = sa.dst;   assign ba.we_in = sa.we;     assign ba.ext_vld = sa.ext_vld;
  assign ba.ext_data = sa.ext_data; assign ba.flush = sa.flush; assign ba.out_rdy = sa.out_rdy;
  assign bb.in_vld = sb.in_vld;  assign bb.src_sel = sb.sel;  assign bb.src_data = sb.sdata;
  assign bb.dst_addr = sb.dst;   assign bb.we_in = sb.we;     assign bb.ext_vld = sb.ext_vld;
  assign bb.ext_data = sb.ext_data; assign bb.flush = sb.flush; assign bb.out_rdy = sb.out_rdy;

  wb_select_stage #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .ADDR_W(ADDR_W), .DEFAULT_IDX(DEF_IDX),
                    .EXT_IDX(EXT_IDX), .EXT_TIMEOUT(TO_A))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ba.slave));
  wb_select_stage #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .ADDR_W(ADDR_W), .DEFAULT_IDX(DEF_IDX),
                    .EXT_IDX(EXT_IDX), .EXT_TIMEOUT(TO_B))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bb.slave));

  function automatic stim_t idle_stim();
    stim_t s;
    s.in_vld = 0; s.sel = '0; s.sdata = '0; s.dst = '0; s.we = 0;
    s.ext_vld = 0; s.ext_data = '0; s.flush = 0; s.out_rdy = 1;
    return s;
  endfunction

  function automatic mdl_t reset_mdl();
    mdl_t m;
    m.vld = 0; m.data = '0; m.addr = '0; m.we = 0; m.err = 0;
    m.waiting = 0; m.waited = 0; m.paddr = '0; m.pwe = 0;
    return m;
  endfunction

  function automatic bit exp_rdy(mdl_t m, stim_t s);
    return !m.waiting && (!m.vld || s.out_rdy) && !s.flush;
  endfunction

  // One clock of the transaction-level behaviour: what the output register holds next.
  function automatic mdl_t mstep(mdl_t m, stim_t s, int to);
    mdl_t n = m;
    bit free = !m.vld || s.out_rdy;
    int lane = DEF_IDX;
    if (s.flush) begin
      n.vld = 0; n.we = 0; n.err = 0; n.waiting = 0; n.waited = 0;
      return n;
    end
    if (m.vld && s.out_rdy) n.vld = 0;
    if (m.waiting) begin
      if (free && s.ext_vld) begin
        n.vld = 1; n.data = s.ext_data; n.addr = m.paddr; n.we = m.pwe; n.err = 0;
        n.waiting = 0;
      end else if (free && m.waited == to - 1) begin
        n.vld = 1; n.data = '0; n.addr = m.paddr; n.we = 0; n.err = 1;
        n.waiting = 0;
      end else begin
        n.waited = (m.waited + 1 > to - 1) ? to - 1 : m.waited + 1;
      end
    end else if (s.in_vld && free) begin
      for (int i = NUM_SRC - 1; i >= 0; i--) if (s.sel[i]) lane = i;
      if (lane == EXT_IDX && !s.ext_vld) begin
        n.waiting = 1; n.waited = 0; n.paddr = s.dst; n.pwe = s.we;
      end else begin
        n.vld = 1; n.addr = s.dst; n.we = s.we; n.err = 0;
        n.data = (lane == EXT_IDX) ? s.ext_data : s.sdata[lane*WIDTH +: WIDTH];
      end
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string t, input logic vld, input logic [WIDTH-1:0] d,
                         input logic [ADDR_W-1:0] a, input logic we, input logic err,
                         input mdl_t m);
    chk({t, ".out_vld"}, 64'(vld), 64'(m.vld));
    chk({t, ".rf_w_data"}, 64'(d), 64'(m.data));
    chk({t, ".rf_w_addr"}, 64'(a), 64'(m.addr));
    chk({t, ".rf_we"}, 64'(we), 64'(m.we));
    chk({t, ".ext_err"}, 64'(err), 64'(m.err));
  endtask

  // Called at a falling edge after inputs are set; returns at the next falling edge.
  task automatic step();
    #1;
    chk("a.in_rdy", 64'(ba.in_rdy), 64'(exp_rdy(ma, sa)));
    chk("a.fwd_vld", 64'(ba.fwd_vld), 64'(ma.vld && ma.we));
    chk("b.in_rdy", 64'(bb.in_rdy), 64'(exp_rdy(mb, sb)));
    chk("b.fwd_vld", 64'(bb.fwd_vld), 64'(mb.vld && mb.we));
    ma = mstep(ma, sa, TO_A);
    mb = mstep(mb, sb, TO_B);
    @(posedge clk);
    #1;
    chk_out("a", ba.out_vld, ba.rf_w_data, ba.rf_w_addr, ba.rf_we, ba.ext_err, ma);
    chk_out("b", bb.out_vld, bb.rf_w_data, bb.rf_w_addr, bb.rf_we, bb.ext_err, mb);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    ma = reset_mdl();
    mb = reset_mdl();
    chk("rst.a.out_vld", 64'(ba.out_vld), 64'd0);
    chk("rst.b.out_vld", 64'(bb.out_vld), 64'd0);
    chk("rst.a.rf_we", 64'(ba.rf_we), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    sa = idle_stim();
    sb = idle_stim();
    ma = reset_mdl();
    mb = reset_mdl();
    @(negedge clk);
    chk("reset.out_vld", 64'(ba.out_vld), 64'd0);
    chk("reset.rf_w_data", 64'(ba.rf_w_data), 64'd0);
    chk("reset.rf_w_addr", 64'(ba.rf_w_addr), 64'd0);
    chk("reset.ext_err", 64'(ba.ext_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // T1: priority, lane 2 beats lane 4
    sa.in_vld = 1; sa.sel = 6'b010100; sa.dst = 4'd7; sa.we = 1;
    sa.sdata[2*WIDTH +: WIDTH] = 32'hAAAA_0002;
    sa.sdata[4*WIDTH +: WIDTH] = 32'h4444_0004;
    step();
    chk("T1.out_vld", 64'(ba.out_vld), 64'd1);
    chk("T1.data", 64'(ba.rf_w_data), 64'hAAAA_0002);
    chk("T1.addr", 64'(ba.rf_w_addr), 64'd7);
    chk("T1.we", 64'(ba.rf_we), 64'd1);

    // T2: default lane and back-pressure
    sa.sel = '0; sa.dst = 4'd3; sa.sdata[5*WIDTH +: WIDTH] = 32'h0000_1234;
    step();
    sa.in_vld = 1; sa.out_rdy = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("T2.in_rdy", 64'(ba.in_rdy), 64'd0);
      chk("T2.data", 64'(ba.rf_w_data), 64'h1234);
      chk("T2.out_vld", 64'(ba.out_vld), 64'd1);
    end
    sa.in_vld = 0; sa.out_rdy = 1;
    step();
    chk("T2.drop", 64'(ba.out_vld), 64'd0);

    // T3: ext wait, result five cycles after accept
    sa.in_vld = 1; sa.sel = 6'b001000; sa.dst = 4'd9; sa.we = 1; sa.ext_vld = 0;
    step();
    sa.in_vld = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("T3.in_rdy", 64'(ba.in_rdy), 64'd0);
      chk("T3.out_vld", 64'(ba.out_vld), 64'd0);
    end
    sa.ext_vld = 1; sa.ext_data = 32'hDEAD_BEEF;
    step();
    sa.ext_vld = 0;
    chk("T3.out_vld", 64'(ba.out_vld), 64'd1);
    chk("T3.data", 64'(ba.rf_w_data), 64'hDEAD_BEEF);
    chk("T3.addr", 64'(ba.rf_w_addr), 64'd9);

    // T4: ext timeout on the short-timeout instance
    sb.in_vld = 1; sb.sel = 6'b001000; sb.dst = 4'd5; sb.we = 1;
    sb.sdata[3*WIDTH +: WIDTH] = 32'h3333_3333;
    step();
    sb.in_vld = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("T4.early", 64'(bb.out_vld), 64'd0);
    end
    step();
    chk("T4.out_vld", 64'(bb.out_vld), 64'd1);
    chk("T4.ext_err", 64'(bb.ext_err), 64'd1);
    chk("T4.rf_we", 64'(bb.rf_we), 64'd0);
    chk("T4.data", 64'(bb.rf_w_data), 64'd0);
    chk("T4.fwd", 64'(bb.fwd_vld), 64'd0);

    // T5: streaming ALU results, no bubbles
    sa.in_vld = 1; sa.sel = 6'b100000;
    for (int i = 0; i < 8; i++) begin
      sa.sdata[5*WIDTH +: WIDTH] = 32'h5000_0000 + 32'(i);
      sa.dst = 4'(i); sa.we = i[0];
      step();
      chk("T5.out_vld", 64'(ba.out_vld), 64'd1);
      chk("T5.data", 64'(ba.rf_w_data), 64'h5000_0000 + 64'(i));
      chk("T5.fwd", 64'(ba.fwd_vld), 64'(i[0]));
    end
    sa.in_vld = 0;
    step();

    // T6: flush during ext wait, then late ext_vld
    sa.in_vld = 1; sa.sel = 6'b001000; sa.dst = 4'd2; sa.ext_vld = 0;
    step();
    sa.in_vld = 0;
    step();
    sa.flush = 1;
    step();
    sa.flush = 0;
    chk("T6.flush.out_vld", 64'(ba.out_vld), 64'd0);
    sa.ext_vld = 1; sa.ext_data = 32'hBAD0_0001;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("T6.late_ext", 64'(ba.out_vld), 64'd0);
    end
    sa.ext_vld = 0;

    // T6: reset with an entry held and with ext work pending
    sa.in_vld = 1; sa.sel = 6'b000001; sa.sdata[0 +: WIDTH] = 32'h0101_0101; sa.out_rdy = 0;
    step();
    sa.in_vld = 0;
    chk("T6.held", 64'(ba.out_vld), 64'd1);
    do_reset();
    sa.out_rdy = 1;
    sa.in_vld = 1; sa.sel = 6'b001000; sa.ext_vld = 0;
    step();
    sa.in_vld = 0;
    do_reset();
    sa.ext_vld = 1;
    step();
    chk("T6.rst.late_ext", 64'(ba.out_vld), 64'd0);
    sa.ext_vld = 0;

    // Random traffic on both instances
    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < 2; k++) begin
        stim_t s = idle_stim();
        s.in_vld   = ($urandom_range(0, 1) == 1);
        s.sel      = NUM_SRC'($urandom) & NUM_SRC'($urandom);
        for (int l = 0; l < int'(NUM_SRC); l++) s.sdata[l*WIDTH +: WIDTH] = $urandom;
        s.dst      = ADDR_W'($urandom);
        s.we       = ($urandom_range(0, 3) != 0);
        s.ext_vld  = ($urandom_range(0, 5) == 0);
        s.ext_data = $urandom;
        s.flush    = ($urandom_range(0, 31) == 0);
        s.out_rdy  = ($urandom_range(0, 3) != 0);
        if (k == 0) sa = s; else sb = s;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
